// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data and downstream valid/ready/data.
// master drives the payload and out_ready; slave is the stage itself.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Skid-buffered pipeline register: main register feeds out_data, skid register absorbs one beat.
// Optional stall counter enabled by defining PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg #(
  parameter int unsigned         WIDTH       = 8,
  parameter logic [WIDTH-1:0]    RESET_VALUE = '0,
  parameter int unsigned         CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
`ifdef PIPE_STAGE_REG_STATS_EN
  output logic [CNT_W-1:0]       stall_cnt,
`endif
  pipe_stage_reg_if.slave        bus
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             up_xfer, dn_xfer;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = main_q;

  assign up_xfer = bus.in_valid & in_ready_q;
  assign dn_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (up_xfer) begin
          state_d = StFull;
          main_d  = bus.in_data;
        end
      end
      StFull: begin
        if (up_xfer && dn_xfer) begin
          main_d = bus.in_data;
        end else if (up_xfer) begin
          state_d = StSkid;
          skid_d  = bus.in_data;
        end else if (dn_xfer) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (bus.out_ready) begin
          state_d = StFull;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush only drops occupancy; the data registers keep their contents.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StEmpty;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StSkid);
    end
  end

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of cycles a valid payload waits on the consumer; flush does not clear it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then random traffic against a
// queue-based model (occupancy = queue size, out_data = oldest entry).
module tb_pipe_stage_reg;

  localparam int unsigned      W     = 8;
  localparam int unsigned      CW    = 2;
  localparam logic [W-1:0]     RSTV  = 8'h00;

  logic clk;
  logic reset;
  logic flush;
`ifdef PIPE_STAGE_REG_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  pipe_stage_reg_if #(.WIDTH(W)) bus ();

  pipe_stage_reg #(
    .WIDTH       (W),
    .RESET_VALUE (RSTV),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
`ifdef PIPE_STAGE_REG_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [W-1:0] exp_q[$];
  int         exp_stall = 0;
  bit         armed = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Stimulus side: record what the stage accepted and apply flush/reset to the expected queue.
  always @(posedge clk) begin : model
    logic         acc;
    logic         f;
    logic         r;
    logic [W-1:0] d;
    r   = reset;
    f   = flush;
    acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    d   = bus.in_data;
    #1;
    if (r === 1'b0) begin
      exp_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (f) exp_q.delete();
      else if (acc) exp_q.push_back(d);
    end
  end

  // Monitor: compare every delivered payload, then audit the visible state shortly after the edge.
  always @(posedge clk) begin : monitor
    if (reset === 1'b0) begin
      exp_stall = 0;
    end else if (armed) begin
      if (exp_q.size() > 0 && bus.out_ready === 1'b0 && exp_stall < (1 << CW) - 1)
        exp_stall++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_delivery", {24'h0, bus.out_data}, 32'hDEAD);
        else chk("delivered_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
    #2;
    if (armed) begin
      chk("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_q.size() != 0});
      chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_q.size() < 2});
      if (exp_q.size() != 0) chk("out_data_head", {24'h0, bus.out_data}, {24'h0, exp_q[0]});
`ifdef PIPE_STAGE_REG_STATS_EN
      chk("stall_cnt", {30'h0, stall_cnt}, exp_stall);
`endif
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy,
                      input logic f, input logic rn);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    flush         = f;
    reset         = rn;
  endtask

  // Called after a reset edge: stage must show the reset image.
  task automatic check_reset_image(input string name);
    @(negedge clk);
    chk({name, "_out_data"}, {24'h0, bus.out_data}, {24'h0, RSTV});
    chk({name, "_out_valid"}, {31'h0, bus.out_valid}, 32'h0);
    chk({name, "_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    reset         = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step(0, 8'h00, 0, 0, 0);
    check_reset_image("reset_idle");

    // Streaming with out_ready high.
    step(1, 8'h11, 1, 0, 1);
    step(1, 8'h22, 1, 0, 1);
    step(1, 8'h33, 1, 0, 1);
    repeat (3) step(0, 8'h00, 1, 0, 1);

    // Backpressure into skid, then drain.
    step(1, 8'hA1, 0, 0, 1);
    step(1, 8'hA2, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    repeat (3) step(0, 8'h00, 1, 0, 1);

    // Flush while holding two entries, with a payload offered in the flush cycle.
    step(1, 8'hA1, 0, 0, 1);
    step(1, 8'hA2, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'hFF, 0, 1, 1);
    repeat (3) step(0, 8'h00, 1, 0, 1);

    // Reset in SKID with a payload offered.
    step(1, 8'hA1, 0, 0, 1);
    step(1, 8'hA2, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h55, 0, 0, 0);
    check_reset_image("reset_midop");
    repeat (3) step(0, 8'h00, 1, 0, 1);

    // Long stall to reach counter saturation.
    step(1, 8'h77, 0, 0, 1);
    repeat (6) step(0, 8'h00, 0, 0, 1);
    repeat (2) step(0, 8'h00, 1, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
    end

    repeat (4) step(0, 8'h00, 1, 0, 1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into all data storage at reset.
REQ-003 The block SHALL have parameter CNT_W, default 16, stall counter width (>=2).
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-005 The block SHALL have port reset  input  1  synchronous active-low reset.
REQ-006 The block SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-009 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 The block SHALL have port out_data  output  WIDTH  oldest held payload.
REQ-013 The block SHALL have port stall_cnt  output  CNT_W  stall-cycle count (present only with PIPE_STAGE_REG_STATS_EN).

Function
REQ-014 Transfers SHALL occur on a rising edge where valid and ready are both high: in_valid&in_ready upstream, out_valid&out_ready downstream.
REQ-015 Storage SHALL be a main register (drives out_data) and one skid register; FSM states EMPTY, FULL, SKID.
REQ-016 in_ready SHALL be registered and equal (state != SKID); out_valid SHALL equal (state != EMPTY); out_data SHALL be the main register directly.
REQ-017 EMPTY: upstream transfer -> FULL, main<=in_data; else stay EMPTY.
REQ-018 FULL: upstream and downstream transfer -> FULL, main<=in_data; upstream only -> SKID, skid<=in_data; downstream only -> EMPTY; neither -> FULL, main held.
REQ-019 SKID: out_ready high -> FULL, main<=skid; else stay SKID, both registers held.
REQ-020 Latency SHALL be one cycle from upstream transfer to out_valid when the stage is empty; ordering SHALL be strictly FIFO; no payload SHALL be duplicated or dropped except by flush or reset.
REQ-021 flush high SHALL force next state EMPTY, discarding main, skid and any payload offered that cycle; a downstream transfer completing in the flush cycle SHALL still count as delivered.
REQ-022 Data registers SHALL not change on flush (only state); out_data is don't-care while out_valid is low.
REQ-023 With out_ready held high, throughput SHALL be one payload per cycle and the stage SHALL never enter SKID.

Reset
REQ-024 reset low at a rising edge SHALL set state EMPTY, main and skid to RESET_VALUE, in_ready to 1, stall_cnt to 0.
REQ-025 Reset SHALL take priority over flush and all transfers, discarding in-flight data mid-operation.
REQ-026 Outputs after reset SHALL be: out_valid=0, out_data=RESET_VALUE, in_ready=1.

Configuration
REQ-027 Macro PIPE_STAGE_REG_STATS_EN defined: stall_cnt present; increments by 1 each cycle with out_valid=1 and out_ready=0, saturates at all-ones, cleared only by reset (not flush).
REQ-028 Macro PIPE_STAGE_REG_STATS_EN undefined: stall_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-029 Reset then idle: reset=0 one cycle -> out_valid=0, out_data=8'h00, in_ready=1, stall_cnt=0.
REQ-030 Streaming: out_ready=1, in_data 8'h11,8'h22,8'h33 on consecutive cycles -> out_data 11,22,33 on the following three cycles, in_ready stays 1.
REQ-031 Backpressure: out_ready=0, send 8'hA1 then 8'hA2 -> out_data=A1, in_ready=0 after second; raise out_ready -> A1 then A2 delivered, in_ready returns 1, stall_cnt=2 after the held cycles (stats build).
REQ-032 Flush in SKID: hold A1/A2 as above, pulse flush with in_valid=1 in_data=8'hFF -> next cycle out_valid=0, in_ready=1, FF never appears.
REQ-033 Reset mid-operation: in SKID, reset=0 with flush=0 and in_valid=1 -> EMPTY, out_data=RESET_VALUE, no payload delivered afterward.
REQ-034 Saturation: CNT_W=2, out_valid held with out_ready=0 for 6 cycles -> stall_cnt reads 3 and holds.
